instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the PC and drives word addresses into Instruction_Mem, which samples the address on posedge clk and returns data one cycle later. Captures returned words into a 2-entry buffer and presents (pc, instruction) pairs to decode through a valid/ready handshake. Supports stall (backpressure), fetch enable, and branch/jump redirect with flush.

Parameters:
RESET_PC, 32'h0000_0000, word address fetched first after reset
DEPTH, 2, output buffer entries (fixed at 2; not to be overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  permits issue of new fetches
redirect_valid  in  1  single-cycle pulse: load new PC, flush
redirect_pc  in  32  target word address for redirect
imem_addr  out  32  word address to Instruction_Mem
imem_rdata  in  32  instruction from Instruction_Mem, valid the cycle after the address was sampled
out_valid  out  1  buffer head holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  32  head instruction
out_pc  out  32  word address of head instruction

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, inflight=0, count=0, buffer pointers=0. Outputs immediately: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. Applies mid-operation with no partial state retained.
- Addressing: word-addressed; PC increments by 1 per issue; 32-bit wrap, 32'hFFFF_FFFF+1 = 0.
- imem_addr = pc_q at all times.
- pop = out_valid & out_ready.
- issue = fetch_en & ~redirect_valid & (count + inflight - pop < 2). On issue: inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+1. No issue: inflight<=0.
- Return: in any cycle with inflight=1 and no redirect, {inflight_pc, imem_rdata} is pushed into the buffer at the clock edge.
- Buffer: 2-entry circular FIFO; push and pop in the same cycle are both honoured; count is unchanged. The issue rule guarantees no overflow. Assert on push when count=2.
- out_valid = (count!=0) & ~redirect_valid. out_instr/out_pc show the head entry, or 0 when count=0.
- Latency: issue in cycle N -> push at the end of N+1 -> out_valid in N+2. With out_ready held at 1, throughput is 1 instruction per cycle.
- Redirect in cycle N has priority over everything else:
  - no pop, no issue, no push in N;
  - buffer cleared; the in-flight return is discarded;
  - pc_q<=redirect_pc;
  - issue of redirect_pc in N+1; out_valid=1 with out_pc=redirect_pc in N+3.
- fetch_en=0: no new issue; an in-flight return still completes into the buffer; buffered entries still drain. Re-assert resumes at pc_q with no skipped or duplicated PC.
- Stall: out_ready=0 with out_valid=1 keeps out_instr/out_pc stable. At most 2 instructions are buffered or outstanding. Issue stops, so imem_addr stays constant.
- Ordering: out_pc must be strictly sequential (+1) between redirects. Each fetched word is delivered exactly once unless flushed.
- out_ready while out_valid=0 is ignored.

Test Plan:
1. Memory word k = 32'h1000_0000+k, release reset, fetch_en=1, out_ready=1 -> out_valid first high 2 cycles after reset release. out_pc 0,1,2,...,13 on consecutive cycles with matching out_instr.
2. Streaming, then out_ready=0 for 5 cycles -> count saturates at 2, imem_addr frozen, head stable. On release, the sequence continues with no gap in out_pc and no duplicates.
3. Buffer full, redirect_valid pulse with redirect_pc=32'h20 -> out_valid=0 in cycles N..N+2. out_pc=32'h20 in N+3, then 32'h21. No pre-redirect instruction appears afterwards.
4. fetch_en dropped mid-stream with out_ready=1 -> at most 2 further instructions delivered, then out_valid=0. Re-enable -> next out_pc = last delivered +1.
5. rst_n asserted asynchronously between clock edges while streaming -> out_valid=0 and imem_addr=RESET_PC before the next edge. After release, the fetch sequence restarts at RESET_PC.
6. Redirect to 32'hFFFF_FFFF -> out_pc 32'hFFFF_FFFF followed by 32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and instruction-memory read initiator with a 2-entry
//               output buffer, valid/ready handshake and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [1:0] c_FULL = 2'(DEPTH);

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;

  logic [31:0] r_buf_pc    [DEPTH];
  logic [31:0] r_buf_instr [DEPTH];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_nonempty;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occupancy;

  assign w_nonempty = (r_count != 2'd0);
  assign out_valid  = w_nonempty & ~redirect_valid;
  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_inflight & ~redirect_valid;

  // Entries held after this edge if nothing new were issued; issuing is only
  // allowed when a slot is guaranteed for the returning word.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = fetch_en & ~redirect_valid & (w_occupancy < {1'b0, c_FULL});

  assign imem_addr = r_pc;
  assign out_pc    = w_nonempty ? r_buf_pc[r_rd_ptr]    : 32'h0000_0000;
  assign out_instr = w_nonempty ? r_buf_instr[r_rd_ptr] : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd1;
      end
    end
  end

  // Payload storage needs no reset: it is only observed through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
      r_buf_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (redirect_valid) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(w_push && (r_count == c_FULL))
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit with a sequence
//               scoreboard, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Instruction memory: address sampled at the edge, data one cycle later.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  // Stream model: between redirects the delivered PCs form one contiguous run.
  always @(negedge clk) begin
    #2;
    if (rst_n !== 1'b1) begin
      exp_pc = RESET_PC;
    end else if (redirect_valid === 1'b1) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_redirect_valid: out_valid=%b want 0", out_valid);
      end
      exp_pc = redirect_pc;
    end else if (out_valid === 1'b1) begin
      n_tests++;
      if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
        n_fail++;
        $display("FAIL sb_order: out_pc=%h out_instr=%h want pc=%h instr=%h",
                 out_pc, out_instr, exp_pc, mem_word(exp_pc));
      end
      if (out_ready === 1'b1) exp_pc = exp_pc + 32'd1;
    end
  end

  task automatic cyc(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n          = 1'b1;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_tests++;
    if (imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC);
    end
    n_tests++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: pc=%h instr=%h want 0/0", out_pc, out_instr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (i < 2) begin
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_latency cyc %0d: out_valid=%b want 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(i - 2)) begin
        n_fail++;
        $display("FAIL stream_seq cyc %0d: valid=%b pc=%h want 1/%h", i, out_valid, out_pc,
                 RESET_PC + 32'(i - 2));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] head_pc, head_instr, addr0;
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    head_pc    = out_pc;
    head_instr = out_instr;
    addr0      = imem_addr;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_valid: got %b want 1", out_valid);
    end
    for (int k = 1; k < 5; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== head_pc || out_instr !== head_instr) begin
        n_fail++;
        $display("FAIL stall_head cyc %0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                 k, out_valid, out_pc, out_instr, head_pc, head_instr);
      end
      n_tests++;
      if (imem_addr !== addr0) begin
        n_fail++; $display("FAIL stall_addr cyc %0d: got %h want %h", k, imem_addr, addr0);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== head_pc + 32'(k)) begin
        n_fail++;
        $display("FAIL stall_release cyc %0d: valid=%b pc=%h want 1/%h",
                 k, out_valid, out_pc, head_pc + 32'(k));
      end
    end
  endtask

  task automatic test_redirect();
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL redirect_bubble N+%0d: out_valid=%b want 0", k, out_valid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h20 + 32'(k)) begin
        n_fail++;
        $display("FAIL redirect_target N+%0d: valid=%b pc=%h want 1/%h",
                 k + 3, out_valid, out_pc, 32'h20 + 32'(k));
      end
    end
  endtask

  task automatic test_fetch_en();
    logic [31:0] last;
    int          delivered;
    bit          idle_seen, revalid, found;
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    last      = out_pc;
    delivered = 0;
    idle_seen = 0;
    revalid   = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) begin
        delivered++;
        last = out_pc;
        if (idle_seen) revalid = 1;
      end else begin
        idle_seen = 1;
      end
    end
    n_tests++;
    if (delivered > 2 || !idle_seen || revalid) begin
      n_fail++;
      $display("FAIL fetch_en_drain: delivered=%0d idle=%0d revalid=%0d want <=2/1/0",
               delivered, idle_seen, revalid);
    end
    n_tests++;
    if (imem_addr !== last + 32'd1) begin
      n_fail++; $display("FAIL fetch_en_hold_addr: got %h want %h", imem_addr, last + 32'd1);
    end
    found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) begin
        found = 1;
        n_tests++;
        if (out_pc !== last + 32'd1) begin
          n_fail++; $display("FAIL fetch_en_resume: pc=%h want %h", out_pc, last + 32'd1);
        end
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL fetch_en_resume_timeout: out_valid=0 want 1 within 4 cycles");
    end
  endtask

  task automatic test_async_reset();
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b addr=%h want 0/%h", out_valid, imem_addr, RESET_PC);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_out: pc=%h instr=%h want 0/0", out_pc, out_instr);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if ((i < 2 && out_valid !== 1'b0) ||
          (i >= 2 && (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(i - 2)))) begin
        n_fail++;
        $display("FAIL async_reset_restart cyc %0d: valid=%b pc=%h", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_wrap();
    bit found;
    found = 0;
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) begin
        found = 1;
        n_tests++;
        if (out_pc !== 32'hFFFF_FFFF) begin
          n_fail++; $display("FAIL wrap_first: pc=%h want ffffffff", out_pc);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          n_fail++; $display("FAIL wrap_next: valid=%b pc=%h want 1/00000000", out_valid, out_pc);
        end
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL wrap_timeout: out_valid=0 want 1 within 6 cycles");
    end
  endtask

  task automatic test_random();
    logic        fe, rv, rdy;
    logic [31:0] rpc;
    for (int k = 0; k < 400; k++) begin
      fe  = ($urandom_range(9) < 8);
      rv  = ($urandom_range(24) == 0);
      rdy = ($urandom_range(9) < 6);
      rpc = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(15)));
      cyc(fe, rv, rpc, rdy);
      // Words fetched but not yet delivered never exceed the buffer depth.
      if (!rv) begin
        n_tests++;
        if ((imem_addr - exp_pc) > 32'd2) begin
          n_fail++;
          $display("FAIL rand_outstanding cyc %0d: addr=%h head=%h want diff<=2", k, imem_addr, exp_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fetch_en();
    test_async_reset();
    test_wrap();
    test_random();
    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
